// File: rtl/stream_xbar_mcast.sv
// Multicast stream crossbar: every input beat is copied to each output in its mask,
// one FIFO per output, round-robin arbitration over the inputs at each output.
module stream_xbar_mcast #(
    parameter int unsigned NumInp    = 2,
    parameter int unsigned NumOut    = 2,
    parameter int unsigned DataWidth = 32,
    parameter type         payload_t = logic [DataWidth-1:0],
    parameter int unsigned FifoDepth = 2,
    parameter int unsigned IdxWidth  = (NumInp > 1) ? $clog2(NumInp) : 1,
    parameter type         idx_inp_t = logic [IdxWidth-1:0]
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  payload_t [NumInp-1:0]            data_i,
    input  logic     [NumInp-1:0][NumOut-1:0] mask_i,
    input  logic     [NumInp-1:0]            valid_i,
    output logic     [NumInp-1:0]            ready_o,
    output payload_t [NumOut-1:0]            data_o,
    output idx_inp_t [NumOut-1:0]            idx_o,
    output logic     [NumOut-1:0]            valid_o,
    input  logic     [NumOut-1:0]            ready_i
);

    logic [NumInp-1:0][NumOut-1:0] done_q;
    logic [NumInp-1:0][NumOut-1:0] gnt;
    idx_inp_t [NumOut-1:0]         rr_q;
    idx_inp_t [NumOut-1:0]         win_idx;
    logic [NumOut-1:0]             win_vld;
    logic [NumOut-1:0]             can_push;
    logic [NumOut-1:0]             push;
    logic                          active;

    assign active = rst_ni & ~flush_i;

    // Per-output round-robin search starting at rr_q, ignoring copies already delivered
    always_comb begin
        int c;
        c       = 0;
        win_vld = '0;
        win_idx = '0;
        for (int j = 0; j < int'(NumOut); j++) begin
            for (int k = 0; k < int'(NumInp); k++) begin
                c = (int'(rr_q[j]) + k) % int'(NumInp);
                if (!win_vld[j] && valid_i[c] && mask_i[c][j] && !done_q[c][j]) begin
                    win_vld[j] = 1'b1;
                    win_idx[j] = IdxWidth'(c);
                end
            end
        end
    end

    always_comb begin
        push = '0;
        gnt  = '0;
        for (int j = 0; j < int'(NumOut); j++) begin
            push[j] = active & win_vld[j] & can_push[j];
            for (int i = 0; i < int'(NumInp); i++) begin
                gnt[i][j] = push[j] && (win_idx[j] == IdxWidth'(i));
            end
        end
    end

    always_comb begin
        ready_o = '0;
        for (int i = 0; i < int'(NumInp); i++) begin
            ready_o[i] = active & valid_i[i]
                       & (((done_q[i] | gnt[i]) & mask_i[i]) == mask_i[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            done_q <= '0;
            rr_q   <= '0;
        end else begin
            for (int i = 0; i < int'(NumInp); i++) begin
                done_q[i] <= ready_o[i] ? '0 : (done_q[i] | gnt[i]);
            end
            for (int j = 0; j < int'(NumOut); j++) begin
                if (push[j]) begin
                    rr_q[j] <= (win_idx[j] == IdxWidth'(NumInp - 1)) ? '0
                                                                     : win_idx[j] + IdxWidth'(1);
                end
            end
        end
    end

    if (FifoDepth > 0) begin : g_fifo
        localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
        localparam int unsigned CntW = $clog2(FifoDepth + 1);

        for (genvar j = 0; j < NumOut; j++) begin : g_out
            payload_t        mem_data [FifoDepth];
            idx_inp_t        mem_idx  [FifoDepth];
            logic [PtrW-1:0] wptr_q;
            logic [PtrW-1:0] rptr_q;
            logic [CntW-1:0] cnt_q;
            logic            pop;

            // A full FIFO refuses pushes even while popping, keeping ready_i off the ready_o path
            assign can_push[j] = (cnt_q != CntW'(FifoDepth));
            assign valid_o[j]  = rst_ni & (cnt_q != '0);
            assign pop         = valid_o[j] & ready_i[j];
            assign data_o[j]   = mem_data[rptr_q];
            assign idx_o[j]    = mem_idx[rptr_q];

            always_ff @(posedge clk_i) begin
                if (!rst_ni || flush_i) begin
                    wptr_q <= '0;
                    rptr_q <= '0;
                    cnt_q  <= '0;
                end else begin
                    if (push[j]) begin
                        wptr_q <= (wptr_q == PtrW'(FifoDepth - 1)) ? '0 : wptr_q + PtrW'(1);
                    end
                    if (pop) begin
                        rptr_q <= (rptr_q == PtrW'(FifoDepth - 1)) ? '0 : rptr_q + PtrW'(1);
                    end
                    if (push[j] && !pop) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end else if (!push[j] && pop) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (push[j]) begin
                    mem_data[wptr_q] <= data_i[win_idx[j]];
                    mem_idx[wptr_q]  <= win_idx[j];
                end
            end
        end
    end else begin : g_bypass
        // No storage: the arbiter winner is presented directly and only granted when ready_i is high
        for (genvar j = 0; j < NumOut; j++) begin : g_out
            assign can_push[j] = ready_i[j];
            assign valid_o[j]  = active & win_vld[j];
            assign data_o[j]   = data_i[win_idx[j]];
            assign idx_o[j]    = win_idx[j];
        end
    end

    for (genvar i = 0; i < NumInp; i++) begin : g_stable
        assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
                         (valid_i[i] && !ready_o[i]) |=>
                         (valid_i[i] && $stable(data_i[i]) && $stable(mask_i[i])))
            else $error("stream_xbar_mcast: input %0d changed while stalled", i);
    end

endmodule

// File: tb/tb_stream_xbar_mcast.sv
// Bench for stream_xbar_mcast (2x2, depth 2): directed scenarios plus a randomized
// run scored against per-(input,output) expected-beat queues.
module tb_stream_xbar_mcast;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic [1:0][31:0]      din;
    logic [1:0][1:0]       msk;
    logic [1:0]            vin;
    logic [1:0]            rdy_o;
    logic [1:0][31:0]      dout;
    logic [1:0][0:0]       idxo;
    logic [1:0]            vout;
    logic [1:0]            rdy_i;

    int errors = 0;
    int checks = 0;

    stream_xbar_mcast #(
        .NumInp   (2),
        .NumOut   (2),
        .DataWidth(32),
        .FifoDepth(2)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .flush_i(flush),
        .data_i (din),
        .mask_i (msk),
        .valid_i(vin),
        .ready_o(rdy_o),
        .data_o (dout),
        .idx_o  (idxo),
        .valid_o(vout),
        .ready_i(rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle;
        vin   = 2'b00;
        msk   = '0;
        din   = '0;
        flush = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0; rdy_i = 2'b11; vin = 2'b11; msk = '1; din = '0; flush = 1'b0;
        #1;
        checks++; if (rdy_o !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", rdy_o); end
        checks++; if (vout !== 2'b00) begin errors++; $display("FAIL rst_valid got=%b exp=00", vout); end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        checks++; if (vout !== 2'b00) begin errors++; $display("FAIL rst_empty got=%b exp=00", vout); end
    endtask

    task automatic test_multicast;
        @(negedge clk);
        rdy_i = 2'b11; din[0] = 32'hA5; msk[0] = 2'b11; vin = 2'b01;
        #1;
        checks++; if (rdy_o !== 2'b01) begin errors++; $display("FAIL mc_ready got=%b exp=01", rdy_o); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (vout !== 2'b11) begin errors++; $display("FAIL mc_valid got=%b exp=11", vout); end
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (dout[j] !== 32'hA5 || idxo[j] !== 1'b0) begin
                errors++; $display("FAIL mc_data%0d got=%h/%0d exp=a5/0", j, dout[j], idxo[j]);
            end
        end
        @(negedge clk);
        #1;
        checks++; if (vout !== 2'b00) begin errors++; $display("FAIL mc_drained got=%b exp=00", vout); end
    endtask

    task automatic test_partial;
        @(negedge clk);
        rdy_i = 2'b00; din[1] = 32'h11; msk[1] = 2'b10; vin = 2'b10;
        #1;
        checks++; if (rdy_o !== 2'b10) begin errors++; $display("FAIL pa_fill1 got=%b exp=10", rdy_o); end
        @(negedge clk);
        din[1] = 32'h22;
        #1;
        checks++; if (rdy_o !== 2'b10) begin errors++; $display("FAIL pa_fill2 got=%b exp=10", rdy_o); end
        @(negedge clk);
        vin = 2'b01; msk[1] = 2'b00; din[0] = 32'h5A; msk[0] = 2'b11; rdy_i = 2'b01;
        #1;
        checks++; if (rdy_o !== 2'b00) begin errors++; $display("FAIL pa_first got=%b exp=00", rdy_o); end
        @(negedge clk);
        #1;
        checks++;
        if (vout !== 2'b11 || dout[0] !== 32'h5A || dout[1] !== 32'h11 || rdy_o !== 2'b00) begin
            errors++; $display("FAIL pa_hold got=v%b d0=%h d1=%h r%b exp=v11 d0=5a d1=11 r00", vout, dout[0], dout[1], rdy_o);
        end
        @(negedge clk);
        rdy_i = 2'b11;
        #1;
        checks++;
        if (vout !== 2'b10 || dout[1] !== 32'h11 || rdy_o !== 2'b00) begin
            errors++; $display("FAIL pa_pop got=v%b d1=%h r%b exp=v10 d1=11 r00", vout, dout[1], rdy_o);
        end
        @(negedge clk);
        rdy_i = 2'b01;
        #1;
        checks++; if (rdy_o !== 2'b01) begin errors++; $display("FAIL pa_complete got=%b exp=01", rdy_o); end
        @(negedge clk);
        idle(); rdy_i = 2'b11;
        #1;
        checks++;
        if (vout !== 2'b10 || dout[1] !== 32'h22 || idxo[1] !== 1'b1) begin
            errors++; $display("FAIL pa_drain1 got=v%b d1=%h i%0d exp=v10 d1=22 i1", vout, dout[1], idxo[1]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (vout !== 2'b10 || dout[1] !== 32'h5A || idxo[1] !== 1'b0) begin
            errors++; $display("FAIL pa_drain2 got=v%b d1=%h i%0d exp=v10 d1=5a i0", vout, dout[1], idxo[1]);
        end
        @(negedge clk);
        #1;
        checks++; if (vout !== 2'b00) begin errors++; $display("FAIL pa_empty got=%b exp=00", vout); end
    endtask

    task automatic test_round_robin;
        int sent [2];
        int got  [2];
        int pops;
        int last;
        sent = '{0, 0}; got = '{0, 0}; pops = 0; last = -1;
        rdy_i = 2'b11;
        for (int cyc = 0; cyc < 40 && pops < 8; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                vin[i] = (sent[i] < 4);
                din[i] = 32'h100 * i + sent[i];
                msk[i] = 2'b01;
            end
            #1;
            if (vout[0]) begin
                int s;
                s = int'(idxo[0]);
                checks++;
                if (dout[0] !== 32'h100 * s + got[s] || s == last) begin
                    errors++; $display("FAIL rr_seq got=%h i%0d last=%0d exp=%h alternating", dout[0], s, last, 32'h100 * s + got[s]);
                end
                got[s]++; pops++; last = s;
            end
            for (int i = 0; i < 2; i++) if (rdy_o[i]) sent[i]++;
        end
        checks++; if (pops !== 8) begin errors++; $display("FAIL rr_count got=%0d exp=8", pops); end
        @(negedge clk);
        idle();
        @(negedge clk);
    endtask

    task automatic test_stall;
        @(negedge clk);
        rdy_i = 2'b10; vin = 2'b01; msk[0] = 2'b01; din[0] = 32'hB0;
        #1;
        checks++; if (rdy_o !== 2'b01) begin errors++; $display("FAIL st_b0 got=%b exp=01", rdy_o); end
        @(negedge clk);
        din[0] = 32'hB1;
        #1;
        checks++; if (rdy_o !== 2'b01) begin errors++; $display("FAIL st_b1 got=%b exp=01", rdy_o); end
        @(negedge clk);
        din[0] = 32'hB2;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (rdy_o !== 2'b00 || vout[0] !== 1'b1 || dout[0] !== 32'hB0) begin
                errors++; $display("FAIL st_hold%0d got=r%b v%b d%h exp=r00 v1 db0", k, rdy_o, vout[0], dout[0]);
            end
            @(negedge clk);
        end
        rdy_i = 2'b11;
        #1;
        checks++;
        if (rdy_o !== 2'b00 || dout[0] !== 32'hB0) begin
            errors++; $display("FAIL st_pop got=r%b d%h exp=r00 db0", rdy_o, dout[0]);
        end
        @(negedge clk);
        rdy_i = 2'b10;
        #1;
        checks++;
        if (rdy_o !== 2'b01 || dout[0] !== 32'hB1) begin
            errors++; $display("FAIL st_refill got=r%b d%h exp=r01 db1", rdy_o, dout[0]);
        end
        @(negedge clk);
        idle(); rdy_i = 2'b11;
        #1;
        checks++; if (dout[0] !== 32'hB1 || vout[0] !== 1'b1) begin errors++; $display("FAIL st_drain1 got=%h exp=b1", dout[0]); end
        @(negedge clk);
        #1;
        checks++; if (dout[0] !== 32'hB2 || vout[0] !== 1'b1) begin errors++; $display("FAIL st_drain2 got=%h exp=b2", dout[0]); end
        @(negedge clk);
    endtask

    task automatic test_drop_flush;
        @(negedge clk);
        rdy_i = 2'b11; vin = 2'b01; msk[0] = 2'b00; din[0] = 32'hDD;
        #1;
        checks++; if (rdy_o !== 2'b01 || vout !== 2'b00) begin errors++; $display("FAIL dr_now got=r%b v%b exp=r01 v00", rdy_o, vout); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (vout !== 2'b00) begin errors++; $display("FAIL dr_none got=%b exp=00", vout); end
        @(negedge clk);
        rdy_i = 2'b00; vin = 2'b10; msk[1] = 2'b10; din[1] = 32'h31;
        @(negedge clk);
        din[1] = 32'h32;
        @(negedge clk);
        vin = 2'b01; msk[1] = 2'b00; msk[0] = 2'b11; din[0] = 32'h77;
        #1;
        checks++; if (rdy_o !== 2'b00) begin errors++; $display("FAIL fl_partial got=%b exp=00", rdy_o); end
        @(negedge clk);
        idle(); flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (vout !== 2'b00) begin errors++; $display("FAIL fl_empty got=%b exp=00", vout); end
        @(negedge clk);
        rdy_i = 2'b11; vin = 2'b01; msk[0] = 2'b01; din[0] = 32'hC3;
        #1;
        checks++; if (rdy_o !== 2'b01) begin errors++; $display("FAIL fl_ready got=%b exp=01", rdy_o); end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (vout !== 2'b01 || dout[0] !== 32'hC3) begin
            errors++; $display("FAIL fl_done_cleared got=v%b d%h exp=v01 dc3", vout, dout[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        rdy_i = 2'b00; vin = 2'b10; msk[1] = 2'b11; din[1] = 32'hD1;
        #1;
        checks++; if (rdy_o !== 2'b10) begin errors++; $display("FAIL rm_fill1 got=%b exp=10", rdy_o); end
        @(negedge clk);
        vin = 2'b01; msk[1] = 2'b00; msk[0] = 2'b11; din[0] = 32'hD0;
        #1;
        checks++; if (rdy_o !== 2'b01) begin errors++; $display("FAIL rm_fill2 got=%b exp=01", rdy_o); end
        @(negedge clk);
        rst_n = 1'b0; vin = 2'b10; msk[0] = 2'b00; msk[1] = 2'b01; din[1] = 32'hE1;
        #1;
        checks++; if (vout !== 2'b00 || rdy_o !== 2'b00) begin errors++; $display("FAIL rm_during got=v%b r%b exp=v00 r00", vout, rdy_o); end
        @(negedge clk);
        rst_n = 1'b1; rdy_i = 2'b11; vin = 2'b11; msk[0] = 2'b01; din[0] = 32'hE0;
        #1;
        checks++; if (vout !== 2'b00 || rdy_o !== 2'b01) begin errors++; $display("FAIL rm_after got=v%b r%b exp=v00 r01", vout, rdy_o); end
        @(negedge clk);
        vin = 2'b10;
        #1;
        checks++;
        if (rdy_o !== 2'b10 || vout !== 2'b01 || dout[0] !== 32'hE0 || idxo[0] !== 1'b0) begin
            errors++; $display("FAIL rm_first got=r%b v%b d%h i%0d exp=r10 v01 de0 i0", rdy_o, vout, dout[0], idxo[0]);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (vout !== 2'b01 || dout[0] !== 32'hE1 || idxo[0] !== 1'b1) begin
            errors++; $display("FAIL rm_second got=v%b d%h i%0d exp=v01 de1 i1", vout, dout[0], idxo[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [31:0] expq [2][2][$];
        logic [31:0] e;
        logic [1:0]        pv;
        logic [1:0]        pr;
        logic [1:0][31:0]  pd;
        bit          pend [2];
        bit          issue;
        bit          quiet;
        int          s;
        pend = '{0, 0}; pv = '0; pr = '0; pd = '0; quiet = 0;
        for (int cyc = 0; cyc < 700 && !quiet; cyc++) begin
            issue = (cyc < 400);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    if (issue && $urandom_range(0, 2) != 0) begin
                        din[i] = $urandom;
                        msk[i] = 2'($urandom);
                        vin[i] = 1'b1;
                        pend[i] = 1;
                        for (int j = 0; j < 2; j++) if (msk[i][j]) expq[i][j].push_back(din[i]);
                    end else begin
                        vin[i] = 1'b0;
                    end
                end
            end
            rdy_i = issue ? 2'($urandom) : 2'b11;
            #1;
            for (int j = 0; j < 2; j++) begin
                if (pv[j] && !pr[j]) begin
                    checks++;
                    if (vout[j] !== 1'b1 || dout[j] !== pd[j]) begin
                        errors++; $display("FAIL rnd_stable%0d got=v%b d%h exp=v1 d%h", j, vout[j], dout[j], pd[j]);
                    end
                end
                if (vout[j] && rdy_i[j]) begin
                    s = int'(idxo[j]);
                    checks++;
                    if (expq[s][j].size() == 0) begin
                        errors++; $display("FAIL rnd_extra out%0d got=%h from in%0d exp=nothing", j, dout[j], s);
                    end else begin
                        e = expq[s][j].pop_front();
                        if (dout[j] !== e) begin
                            errors++; $display("FAIL rnd_data out%0d in%0d got=%h exp=%h", j, s, dout[j], e);
                        end
                    end
                end
            end
            for (int i = 0; i < 2; i++) if (rdy_o[i]) pend[i] = 0;
            pv = vout; pr = rdy_i; pd = dout;
            quiet = !issue && !pend[0] && !pend[1] && (expq[0][0].size() + expq[0][1].size()
                    + expq[1][0].size() + expq[1][1].size() == 0);
        end
        checks++;
        if (!quiet) begin
            errors++; $display("FAIL rnd_drain got=pending %0d%0d left %0d exp=all delivered", pend[0], pend[1],
                               expq[0][0].size() + expq[0][1].size() + expq[1][0].size() + expq[1][1].size());
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        rdy_i = 2'b11;
        idle();
        repeat (2) @(negedge clk);
        test_reset();
        test_multicast();
        test_partial();
        test_round_robin();
        test_stall();
        test_drop_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
